// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-requester arbiter sharing one pipelined signed multiplier core
//
// Purpose:
//   Arbitrates two valid/ready operand streams onto a single pipelined
//   multiplier core and steers each product back to the requester that
//   issued it.
//   Optional: define MUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0
//   wins). Without the macro, contention is resolved round-robin.
//
// Ports:
//   sys_clk, sys_rst_n       clock, synchronous active-low reset
//   req{0,1}_valid/_ready    operand handshake per requester
//   req{0,1}_a/_b            signed operands per requester
//   mul_valid, mul_a, mul_b  registered issue to the core
//   mul_p                    core product, MUL_LAT cycles after mul_valid
//   res{0,1}_valid/_p        one-cycle result strobe and held product

module mul_share_arbiter #(
  parameter int DW      = 16,
  parameter int MUL_LAT = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            mul_valid,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic [2*DW-1:0] mul_p,
  output logic            res0_valid,
  output logic [2*DW-1:0] res0_p,
  output logic            res1_valid,
  output logic [2*DW-1:0] res1_p
);

  if (MUL_LAT < 1 || MUL_LAT > 8) begin : g_bad_mul_lat
    $error("mul_share_arbiter: MUL_LAT must be within 1..8");
  end

  logic              last_grant_q, last_grant_d;
  logic              gnt0, gnt1, accept;

  logic              mul_valid_q, mul_valid_d;
  logic [DW-1:0]     mul_a_q, mul_a_d;
  logic [DW-1:0]     mul_b_q, mul_b_d;
  logic              issue_id_q, issue_id_d;

  logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0] tag_id_q, tag_id_d;
  logic              tag_hit, tag_id;

  logic              res0_valid_q, res0_valid_d;
  logic [2*DW-1:0]   res0_p_q, res0_p_d;
  logic              res1_valid_q, res1_valid_d;
  logic [2*DW-1:0]   res1_p_q, res1_p_d;

  // Grant is held low during reset so no handshake can complete while the
  // pipeline is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (sys_rst_n) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  // A grant is only ever raised for a valid requester, so grant == accept.
  assign accept = gnt0 | gnt1;

  always_comb begin
    last_grant_d = last_grant_q;
    mul_valid_d  = accept;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    issue_id_d   = issue_id_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      mul_a_d      = req0_a;
      mul_b_d      = req0_b;
      issue_id_d   = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      mul_a_d      = req1_a;
      mul_b_d      = req1_b;
      issue_id_d   = 1'b1;
    end
  end

  // Tag stage 0 follows the issue register, so the last stage lines up with
  // the cycle in which the core presents the matching product.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = mul_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  assign tag_hit = tag_vld_q[MUL_LAT-1];
  assign tag_id  = tag_id_q[MUL_LAT-1];

  always_comb begin
    res0_valid_d = tag_hit & ~tag_id;
    res1_valid_d = tag_hit & tag_id;
    res0_p_d     = res0_valid_d ? mul_p : res0_p_q;
    res1_p_d     = res1_valid_d ? mul_p : res1_p_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      last_grant_q <= 1'b1;
      mul_valid_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      issue_id_q   <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      res0_valid_q <= 1'b0;
      res0_p_q     <= '0;
      res1_valid_q <= 1'b0;
      res1_p_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_valid_q  <= mul_valid_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      issue_id_q   <= issue_id_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      res0_valid_q <= res0_valid_d;
      res0_p_q     <= res0_p_d;
      res1_valid_q <= res1_valid_d;
      res1_p_q     <= res1_p_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_valid  = mul_valid_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign res0_valid = res0_valid_q;
  assign res0_p     = res0_p_q;
  assign res1_valid = res1_valid_q;
  assign res1_p     = res1_p_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  localparam int DW  = 16;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic            mul_valid;
  logic [DW-1:0]   mul_a, mul_b;
  logic [2*DW-1:0] mul_p;
  logic            res0_valid, res1_valid;
  logic [2*DW-1:0] res0_p, res1_p;

  always #5 clk = ~clk;

  mul_share_arbiter #(.DW(DW), .MUL_LAT(LAT)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res0_valid(res0_valid), .res0_p(res0_p), .res1_valid(res1_valid), .res1_p(res1_p)
  );

  // Two-stage core model: product appears LAT=2 cycles after the operands.
  logic signed [2*DW-1:0] core_p1, core_p2;
  always @(posedge clk) begin
    core_p1 <= $signed(mul_a) * $signed(mul_b);
    core_p2 <= core_p1;
  end
  assign mul_p = core_p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] p;
  } exp_t;
  exp_t expq[$];
  exp_t e;

  // Called in the accept cycle; the result strobe is LAT+2 cycles later.
  task automatic push_exp(input logic id, input logic [31:0] p);
    exp_t x;
    x.cyc = cyc + LAT + 2;
    x.id  = id;
    x.p   = p;
    expq.push_back(x);
  endtask

  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_result: got none expected id %0d p 0x%0h at cycle %0d",
               expq[0].id, expq[0].p, expq[0].cyc);
      void'(expq.pop_front());
    end
    if (res0_valid || res1_valid) begin
      if (res0_valid && res1_valid) check("dual_strobe", 32'd1, 32'd0);
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got res0_valid=%0b res1_valid=%0b expected no strobe",
                 res0_valid, res1_valid);
      end else begin
        e = expq.pop_front();
        check("res_cycle", cyc, e.cyc);
        check("res_id", {31'd0, res1_valid}, {31'd0, e.id});
        check("res_p", res1_valid ? res1_p : res0_p, e.p);
      end
    end
  end

  typedef struct {
    logic        v0;
    logic [15:0] a0, b0;
    logic        v1;
    logic [15:0] a1, b1;
    logic        r0, r1;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                     input logic r0, input logic r1, input logic [31:0] p);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.r0 = r0; v.r1 = r1; v.p = p;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_mul_valid"},  {31'd0, mul_valid},  32'd0);
    check({tag, "_mul_a"},      {16'd0, mul_a},      32'd0);
    check({tag, "_mul_b"},      {16'd0, mul_b},      32'd0);
    check({tag, "_res0_valid"}, {31'd0, res0_valid}, 32'd0);
    check({tag, "_res0_p"},     res0_p,              32'd0);
    check({tag, "_res1_valid"}, {31'd0, res1_valid}, 32'd0);
    check({tag, "_res1_p"},     res1_p,              32'd0);
  endtask

  initial begin
`ifdef MUL_ARB_FIXED_PRIO_EN
    add(1, 16'h0001, 16'h0001, 1, 16'h0005, 16'h0005, 1, 0, 32'h00000001);
    add(1, 16'h0002, 16'h0002, 1, 16'h0005, 16'h0005, 1, 0, 32'h00000004);
    add(1, 16'h0003, 16'h0003, 1, 16'h0005, 16'h0005, 1, 0, 32'h00000009);
    add(1, 16'h0004, 16'h0004, 1, 16'h0005, 16'h0005, 1, 0, 32'h00000010);
    add(0, 16'h0000, 16'h0000, 1, 16'h0005, 16'h0005, 0, 1, 32'h00000019);
`else
    // Contention from the first cycle after reset: 0,1,0,1,0,1.
    add(1, 16'h0002, 16'h0003, 1, 16'h0004, 16'h0005, 1, 0, 32'h00000006);
    add(1, 16'hFFFE, 16'h0007, 1, 16'h0004, 16'h0005, 0, 1, 32'h00000014);
    add(1, 16'hFFFE, 16'h0007, 1, 16'h7FFF, 16'h7FFF, 1, 0, 32'hFFFFFFF2);
    add(1, 16'h8000, 16'h8000, 1, 16'h7FFF, 16'h7FFF, 0, 1, 32'h3FFF0001);
    add(1, 16'h8000, 16'h8000, 1, 16'h8000, 16'h0001, 1, 0, 32'h40000000);
    add(1, 16'h0010, 16'h0010, 1, 16'h8000, 16'h0001, 0, 1, 32'hFFFF8000);
    // Idle gap: req0, req0, nothing, req1.
    add(1, 16'h0003, 16'h0003, 0, 16'h0000, 16'h0000, 1, 0, 32'h00000009);
    add(1, 16'h0004, 16'h0004, 0, 16'h0000, 16'h0000, 1, 0, 32'h00000010);
    add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 32'h00000000);
    add(0, 16'h0000, 16'h0000, 1, 16'h0005, 16'h0005, 0, 1, 32'h00000019);
    // req1 loses contention, then withdraws before being granted.
    add(1, 16'h0006, 16'h0006, 1, 16'h0007, 16'h0007, 1, 0, 32'h00000024);
    add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 32'h00000000);
    add(0, 16'h0000, 16'h0000, 1, 16'h0001, 16'hFFFF, 0, 1, 32'hFFFFFFFF);
`endif

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_all_zero("reset");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    #1;
    check("single_ready0", {31'd0, req0_ready}, 32'd1);
    check("single_ready1", {31'd0, req1_ready}, 32'd0);
    push_exp(1'b0, 32'h0000000F);
    @(negedge clk);
    idle_inputs();
    check("single_mul_valid", {31'd0, mul_valid}, 32'd1);
    check("single_mul_a", {16'd0, mul_a}, 32'd3);
    check("single_mul_b", {16'd0, mul_b}, 32'd5);
    @(negedge clk);
    check("idle_mul_valid", {31'd0, mul_valid}, 32'd0);
    check("hold_mul_a", {16'd0, mul_a}, 32'd3);
    repeat (4) @(negedge clk);
    check("single_res0_p", res0_p, 32'h0000000F);

    // Signed passthrough on requester 1.
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0002;
    #1;
    check("signed_ready1", {31'd0, req1_ready}, 32'd1);
    push_exp(1'b1, 32'hFFFFFFFE);
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    check("signed_res1_p", res1_p, 32'hFFFFFFFE);
    check("signed_res0_hold", res0_p, 32'h0000000F);

    // Fresh reset so contention starts with last_grant = 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
      req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
      #1;
      check($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
      check($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
      if (vecs[i].r0) push_exp(1'b0, vecs[i].p);
      if (vecs[i].r1) push_exp(1'b1, vecs[i].p);
      @(negedge clk);
    end
    idle_inputs();
    repeat (8) @(negedge clk);

    // Reset while two products are in flight: neither may ever strobe.
    req0_valid = 1'b1; req0_a = 16'h0011; req0_b = 16'h0011;
    #1;
    check("flight0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_a = 16'h0012; req0_b = 16'h0012;
    #1;
    check("flight1_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_all_zero("midreset");
    idle_inputs();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd9;
    #1;
    check("post_reset_ready0", {31'd0, req0_ready}, 32'd1);
    push_exp(1'b0, 32'h0000003F);
    @(negedge clk);
    idle_inputs();
    repeat (8) @(negedge clk);

    check("all_results_seen", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 16x16 signed Booth/Wallace multiplier core between two requesters.
- Arbitrates operand requests with valid/ready handshakes: round-robin by default, fixed priority optionally.
- Registers the granted operands into the core and tracks in-flight ownership with a tag pipeline matched to the core latency.
- Steers each registered product back to the requester that issued it.

Parameters:
- DW, 16, operand width per input; product width is 2*DW.
- MUL_LAT, 2, cycles from mul_valid/mul_a/mul_b to mul_p valid at the core output; legal range 1..8.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a  input  DW  requester 0 multiplicand, signed
- req0_b  input  DW  requester 0 multiplier, signed
- req1_valid  input  1  requester 1 has operands
- req1_ready  output  1  requester 1 accepted this cycle
- req1_a  input  DW  requester 1 multiplicand, signed
- req1_b  input  DW  requester 1 multiplier, signed
- mul_valid  output  1  issue strobe to the core
- mul_a  output  DW  registered multiplicand to the core
- mul_b  output  DW  registered multiplier to the core
- mul_p  input  2*DW  core product, valid MUL_LAT cycles after mul_valid
- res0_valid  output  1  one-cycle strobe, res0_p valid
- res0_p  output  2*DW  product for requester 0
- res1_valid  output  1  one-cycle strobe, res1_p valid
- res1_p  output  2*DW  product for requester 1

Behaviour:
- Reset: synchronous, active-low, sampled on the sys_clk rising edge.
  - While sys_rst_n=0, all outputs are 0: req*_ready, mul_valid, mul_a, mul_b, res*_valid, res*_p.
  - last_grant resets to 1, so requester 0 wins the first contention.
- Grant is combinational from req0_valid, req1_valid and last_grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
  - reqX_ready = grant X. Ready is never high while reqX_valid=0, and never high during reset.
- Accept: reqX_valid & reqX_ready.
  - On accept, last_grant <= X.
  - Next cycle: mul_valid=1 and mul_a/mul_b = the accepted operands.
  - No accept: mul_valid=0; mul_a/mul_b hold their last values.
- Throughput: one accept per cycle, no bubbles. Requests are never dropped; an unaccepted requester holds its valid and operands.
- Tag pipeline:
  - MUL_LAT-stage shift register of {vld, id}; stage 0 is loaded together with mul_valid.
  - At the stage MUL_LAT-1 output, vld=1 marks mul_p as valid and belonging to id.
- Result register:
  - On a tagged-valid mul_p, res{id}_p <= mul_p and res{id}_valid=1 for exactly one cycle.
  - The other requester's res*_p holds its value; its valid stays 0.
  - Results have no backpressure; requesters must always sink them.
- Latency: accept edge to resX_valid = MUL_LAT+2 cycles.
  - 1 cycle issue register, MUL_LAT cycles in the core, 1 cycle result register.
  - Results return in issue order.
- Arithmetic: none in this block. Operands and products pass through bit-exact; sign handling belongs to the core.
- Boundary conditions:
  - Reset mid-operation clears every tag-pipeline vld, so in-flight products never produce a result strobe, including after reset releases.
  - Simultaneous valid on both requesters for N cycles gives alternating grants.
  - A requester deasserting valid before it is granted is allowed and has no side effects.
  - An illegal MUL_LAT outside 1..8 must be rejected at elaboration.

Optional Feature:
- Macro: MUL_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins contention; requester 1 is granted only when req0_valid=0.
  - last_grant is still updated on each accept but is not used for grant decisions.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single request, MUL_LAT=2, bench core model registers a*b: req0 a=3, b=5 accepted at cycle T.
  - Required: mul_valid at T+1; res0_valid at T+4 with res0_p=0x0000000F; res1_valid stays 0.
- Signed passthrough: req1 a=0xFFFF (-1), b=0x0002.
  - Required: res1_p=0xFFFFFFFE; res0_p unchanged.
- Contention:
  - Both valid from the first cycle after reset for 6 cycles, distinct operands.
  - Required: grants 0,1,0,1,0,1; six results return in that order to the matching ports; one per cycle, no gaps.
- Idle gap: req0 valid cycles 0..1, nothing in cycle 2, req1 valid in cycle 3.
  - Required: exactly three results, ids 0,0,1, with one idle result cycle matching the gap.
- Reset mid-flight: accept two requests, then drive sys_rst_n=0 for one cycle two cycles later.
  - Required: no res*_valid ever fires for them; all outputs are 0 during reset; the first request after reset completes normally.
- With MUL_ARB_FIXED_PRIO_EN: both valid for 4 cycles.
  - Required: grants 0,0,0,0 and req1_ready stays 0.
  - Then drop req0_valid: req1 is granted the next cycle.
